jtdsp16_cache: RTL
==================

JTDSP16_CACHE -- requirements
Module: jtdsp16_cache

Interface
REQ-001 SHALL have port: clk  in  1  system clock, all state updated on its rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: cen  in  1  clock enable; state changes only when cen=1.
REQ-004 SHALL have port: do_start  in  1  one-cycle pulse from the instruction decoder on a do/redo instruction.
REQ-005 SHALL have port: do_data  in  11  [10:7]=NI (instructions in loop body, 0 means redo), [6:0]=K (iteration count).
REQ-006 SHALL have port: inst_adv  in  1  decoder consumed the current instruction word; low while the decoder stalls on two-cycle instructions.
REQ-007 SHALL have port: rom_dout  in  16  instruction word from program ROM.
REQ-008 SHALL have port: cache_dout  out  16  instruction word replayed from cache.
REQ-009 SHALL have port: cache_en  out  1  decoder takes cache_dout instead of rom_dout.
REQ-010 SHALL have port: pc_hold  out  1  XAAU freezes PC (replay in progress).
REQ-011 SHALL have port: no_int  out  1  interrupts blocked while a loop is active.
REQ-012 SHALL have port: fault  out  1  sticky illegal-use flag (debug).

Function
REQ-013 SHALL implement states IDLE, LOAD, REPLAY, REDO; cache_en=pc_hold=1 in REPLAY and REDO only; no_int=1 in any state but IDLE.
REQ-014 SHALL hold a 15x16 instruction store, 4-bit wr_ptr/rd_ptr, 4-bit ni register, 7-bit iter_left counter, 1-bit cache_valid.
REQ-015 IDLE + do_start + NI!=0 SHALL latch ni=NI, wr_ptr=0, iter_left=K-1, clear cache_valid, go to LOAD next cycle.
REQ-016 LOAD: each inst_adv SHALL write rom_dout to mem[wr_ptr] and increment wr_ptr; cycles without inst_adv change nothing.
REQ-017 LOAD: inst_adv with wr_ptr==ni-1 SHALL set cache_valid, rd_ptr=0, go to REPLAY if iter_left!=0, else IDLE.
REQ-018 REPLAY/REDO: cache_dout SHALL equal mem[rd_ptr] combinationally; each inst_adv increments rd_ptr.
REQ-019 REPLAY/REDO: inst_adv with rd_ptr==ni-1 SHALL set rd_ptr=0 and decrement iter_left; if iter_left was 1, go to IDLE (cache_en drops the following cycle, PC resumes at instruction after loop body).
REQ-020 IDLE + do_start + NI==0 (redo) with cache_valid=1 SHALL set iter_left=K, rd_ptr=0, go to REDO reusing stored ni and contents.
REQ-021 Redo with cache_valid=0, or K==0 on either form, SHALL set fault and remain IDLE.
REQ-022 K==1 with NI!=0 SHALL perform LOAD only (single pass), then IDLE with cache_valid=1.
REQ-023 do_start while not IDLE (nested do) SHALL set fault and be ignored; the running loop continues unchanged.
REQ-024 do_start and the final inst_adv of a loop in the same cycle SHALL be treated as nested (fault, ignored).
REQ-025 Store contents SHALL persist across IDLE periods until the next non-redo do_start.

Reset
REQ-026 rst SHALL force state=IDLE, wr_ptr=rd_ptr=0, ni=0, iter_left=0, cache_valid=0, fault=0, cache_en=pc_hold=no_int=0; store contents need not be cleared.
REQ-027 rst asserted mid-LOAD or mid-REPLAY SHALL abandon the loop immediately; a later redo SHALL fault.

Structure
REQ-028 do_data field positions (NI [10:7], K [6:0]) and state encodings SHALL be localparams in the shared jtdsp16 header used by the decoder.
REQ-029 The 15x16 store SHALL be a sub-module jtdsp16_cache_mem (1 write port, 1 async read port); control stays in jtdsp16_cache.

Verification
REQ-030 do_data={4'd3,7'd4}, feed 0x1111,0x2222,0x3333 with inst_adv each cycle -> LOAD 3 cycles, then cache_dout 0x1111,0x2222,0x3333 repeated 3 times, pc_hold high 9 advances, then IDLE.
REQ-031 Same loop with inst_adv low on alternate cycles during REPLAY -> rd_ptr holds on stall cycles, total replay still 9 advances, identical word sequence.
REQ-032 After REQ-030, do_data={4'd0,7'd2} -> REDO replays 0x1111..0x3333 twice with no LOAD; fault stays 0.
REQ-033 Redo directly after reset, and do with K=0 -> fault=1, state IDLE, cache_en=0.
REQ-034 do_start during REPLAY of a 2-instruction, K=5 loop -> fault=1, loop completes all 5 passes.
REQ-035 rst pulse during second REPLAY pass -> all outputs 0 next cycle; subsequent redo sets fault.

Source files
------------

// File: rtl/jtdsp16_cache_pkg.sv
// Shared do/redo loop cache definitions for the decoder and the cache.
// Latency: n/a (constants, types and field helpers only).
// Backpressure: n/a.
//
// Holds the do_data field positions, the cache FSM state encodings and the
// store depth, so the decoder and the cache agree on one definition.
package jtdsp16_cache_pkg;

  // do_data layout: [10:7] = NI (loop body length, 0 = redo), [6:0] = K
  localparam int DO_NI_MSB = 10;
  localparam int DO_NI_LSB = 7;
  localparam int DO_K_MSB  = 6;
  localparam int DO_K_LSB  = 0;

  // Instruction store depth (largest loop body a do can cache)
  localparam int CACHE_DEPTH = 15;

  // Cache FSM state encodings
  localparam logic [1:0] CACHE_IDLE   = 2'd0;
  localparam logic [1:0] CACHE_LOAD   = 2'd1;
  localparam logic [1:0] CACHE_REPLAY = 2'd2;
  localparam logic [1:0] CACHE_REDO   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = CACHE_IDLE,
    ST_LOAD   = CACHE_LOAD,
    ST_REPLAY = CACHE_REPLAY,
    ST_REDO   = CACHE_REDO
  } cache_state_t;

  function automatic logic [3:0] do_ni(input logic [10:0] d);
    return d[DO_NI_MSB:DO_NI_LSB];
  endfunction

  function automatic logic [6:0] do_k(input logic [10:0] d);
    return d[DO_K_MSB:DO_K_LSB];
  endfunction

endpackage

// File: rtl/jtdsp16_cache_mem.sv
// 15x16 loop-body store: one synchronous write port, one async read port.
// Latency: write lands on the next rising clk; read is combinational.
// Backpressure: none; the write enable already carries cen and inst_adv.
//
// Ports: clk; we/wr_addr/wr_data write port; rd_addr/rd_data read port.
// Contents are never reset; they live until overwritten by a new do.
import jtdsp16_cache_pkg::*;

module jtdsp16_cache_mem (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [3:0]  rd_addr,
  output logic [15:0] rd_data
);

  logic [15:0] mem [CACHE_DEPTH];

  // Address 15 does not exist; the control never produces it, but guard anyway
  always_ff @(posedge clk) begin
    if (we && (wr_addr < 4'(CACHE_DEPTH))) mem[wr_addr] <= wr_data;
  end

  assign rd_data = (rd_addr < 4'(CACHE_DEPTH)) ? mem[rd_addr] : 16'h0000;

endmodule

// File: rtl/jtdsp16_cache.sv
// DSP16 do/redo loop cache: records the loop body from ROM, then replays it.
// Latency: state moves one clk after the qualifying cen cycle; cache_dout is
// combinational from the store. Backpressure: inst_adv low freezes pointers.
//
// Ports: clk, rst (async, active high), cen (clock enable);
//   do_start/do_data  do/redo request from the decoder
//   inst_adv/rom_dout instruction consumed / instruction word from ROM
//   cache_dout, cache_en, pc_hold  replay path to decoder and XAAU
//   no_int  loop active, fault  sticky illegal-use flag
import jtdsp16_cache_pkg::*;

module jtdsp16_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        do_start,
  input  logic [10:0] do_data,
  input  logic        inst_adv,
  input  logic [15:0] rom_dout,
  output logic [15:0] cache_dout,
  output logic        cache_en,
  output logic        pc_hold,
  output logic        no_int,
  output logic        fault
);

  cache_state_t state;
  logic [3:0]   wr_ptr;
  logic [3:0]   rd_ptr;
  logic [3:0]   ni;
  logic [6:0]   iter_left;
  logic         cache_valid;

  logic [3:0]   req_ni;
  logic [6:0]   req_k;
  logic         last_wr;
  logic         last_rd;
  logic         mem_we;
  logic [15:0]  rd_data;

  assign req_ni  = do_ni(do_data);
  assign req_k   = do_k(do_data);
  assign last_wr = (wr_ptr == (ni - 4'd1));
  assign last_rd = (rd_ptr == (ni - 4'd1));
  assign mem_we  = cen && inst_adv && (state == ST_LOAD);

  jtdsp16_cache_mem u_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (wr_ptr),
    .wr_data (rom_dout),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Outputs decode straight from the state flop, so they change only on clk
  assign cache_en   = (state == ST_REPLAY) || (state == ST_REDO);
  assign pc_hold    = cache_en;
  assign no_int     = (state != ST_IDLE);
  assign cache_dout = cache_en ? rd_data : 16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wr_ptr      <= 4'd0;
      rd_ptr      <= 4'd0;
      ni          <= 4'd0;
      iter_left   <= 7'd0;
      cache_valid <= 1'b0;
      fault       <= 1'b0;
    end else if (cen) begin
      case (state)
        ST_IDLE: begin
          if (do_start) begin
            if (req_k == 7'd0) begin
              fault <= 1'b1;
            end else if (req_ni != 4'd0) begin
              // The first pass runs while loading, hence K-1 passes remain
              ni          <= req_ni;
              wr_ptr      <= 4'd0;
              iter_left   <= req_k - 7'd1;
              cache_valid <= 1'b0;
              state       <= ST_LOAD;
            end else if (cache_valid) begin
              // Redo replays every pass from the store
              iter_left <= req_k;
              rd_ptr    <= 4'd0;
              state     <= ST_REDO;
            end else begin
              fault <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          // Nested do: flag it, keep loading as if nothing happened
          if (do_start) fault <= 1'b1;
          if (inst_adv) begin
            wr_ptr <= wr_ptr + 4'd1;
            if (last_wr) begin
              cache_valid <= 1'b1;
              rd_ptr      <= 4'd0;
              state       <= (iter_left != 7'd0) ? ST_REPLAY : ST_IDLE;
            end
          end
        end

        default: begin // ST_REPLAY, ST_REDO
          if (do_start) fault <= 1'b1;
          if (inst_adv) begin
            if (last_rd) begin
              rd_ptr    <= 4'd0;
              iter_left <= iter_left - 7'd1;
              if (iter_left == 7'd1) state <= ST_IDLE;
            end else begin
              rd_ptr <= rd_ptr + 4'd1;
            end
          end
        end
      endcase
    end
  end

endmodule
